// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage_pkg
//  Description : Bus widths, ALU operation codes, result-class codes and
//                divider state encoding shared by the execute stage.
//  Revision    : 1.0  initial release
// ============================================================================
package ex_stage_pkg;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALUOP_W    = 8;
    localparam int ALUTYPE_W  = 3;

    // Operation codes
    localparam logic [ALUOP_W-1:0] EXE_NOP_OP   = 8'h00;
    localparam logic [ALUOP_W-1:0] EXE_AND_OP   = 8'h24;
    localparam logic [ALUOP_W-1:0] EXE_OR_OP    = 8'h25;
    localparam logic [ALUOP_W-1:0] EXE_XOR_OP   = 8'h26;
    localparam logic [ALUOP_W-1:0] EXE_NOR_OP   = 8'h27;
    localparam logic [ALUOP_W-1:0] EXE_SLL_OP   = 8'h7C;
    localparam logic [ALUOP_W-1:0] EXE_SRL_OP   = 8'h02;
    localparam logic [ALUOP_W-1:0] EXE_SRA_OP   = 8'h03;
    localparam logic [ALUOP_W-1:0] EXE_ADD_OP   = 8'h20;
    localparam logic [ALUOP_W-1:0] EXE_ADDU_OP  = 8'h21;
    localparam logic [ALUOP_W-1:0] EXE_SUB_OP   = 8'h22;
    localparam logic [ALUOP_W-1:0] EXE_SUBU_OP  = 8'h23;
    localparam logic [ALUOP_W-1:0] EXE_SLT_OP   = 8'h2A;
    localparam logic [ALUOP_W-1:0] EXE_SLTU_OP  = 8'h2B;
    localparam logic [ALUOP_W-1:0] EXE_MULT_OP  = 8'h18;
    localparam logic [ALUOP_W-1:0] EXE_MULTU_OP = 8'h19;
    localparam logic [ALUOP_W-1:0] EXE_DIV_OP   = 8'h1A;
    localparam logic [ALUOP_W-1:0] EXE_DIVU_OP  = 8'h1B;
    localparam logic [ALUOP_W-1:0] EXE_MFHI_OP  = 8'h10;
    localparam logic [ALUOP_W-1:0] EXE_MTHI_OP  = 8'h11;
    localparam logic [ALUOP_W-1:0] EXE_MFLO_OP  = 8'h12;
    localparam logic [ALUOP_W-1:0] EXE_MTLO_OP  = 8'h13;

    // Result classes selecting the GPR write data
    localparam logic [ALUTYPE_W-1:0] EXE_RES_NOP   = 3'd0;
    localparam logic [ALUTYPE_W-1:0] EXE_RES_LOGIC = 3'd1;
    localparam logic [ALUTYPE_W-1:0] EXE_RES_SHIFT = 3'd2;
    localparam logic [ALUTYPE_W-1:0] EXE_RES_ARITH = 3'd3;
    localparam logic [ALUTYPE_W-1:0] EXE_RES_MOVE  = 3'd4;

    // Divider states
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_ZERO = 2'd2,
        DIV_END  = 2'd3
    } div_state_t;

    // Magnitude of a two's-complement value when en is set, raw value otherwise
    function automatic logic [REG_W-1:0] abs32(input logic [REG_W-1:0] v, input logic en);
        return (en && v[REG_W-1]) ? (~v + 32'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_stage_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage_div_unit
//  Description : Iterative radix-2 restoring divider (div_unit) with
//                signed/unsigned operand handling and annul support.
//  Revision    : 1.0  initial release
// ============================================================================
module ex_stage_div_unit
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic             annul,
    input  logic [REG_W-1:0] op_a,
    input  logic [REG_W-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [REG_W-1:0] quotient,
    output logic [REG_W-1:0] remainder
);

    localparam int CNT_W = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(DIV_CYCLES - 1);

    div_state_t         r_state;
    div_state_t         w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [64:0]        r_shift;      // {partial remainder[64:32], quotient/dividend[31:0]}
    logic [REG_W-1:0]   r_divisor;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [33:0]        w_diff;
    logic [64:0]        w_step;

    // One restoring step: trial-subtract divisor from the shifted partial remainder
    always_comb begin
        w_diff = r_shift[64:31] - {2'b00, r_divisor};
        if (w_diff[33]) begin
            w_step = {r_shift[63:0], 1'b0};
        end else begin
            w_step = {w_diff[32:0], r_shift[30:0], 1'b1};
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                if (start && !annul) begin
                    busy   = 1'b1;
                    w_next = (op_b == '0) ? DIV_ZERO : DIV_CALC;
                end
            end
            DIV_CALC: begin
                busy = 1'b1;
                if (annul) begin
                    w_next = DIV_IDLE;
                end else if (r_cnt == C_LAST_CNT) begin
                    w_next = DIV_END;
                end
            end
            DIV_ZERO: begin
                busy   = 1'b1;
                w_next = annul ? DIV_IDLE : DIV_END;
            end
            DIV_END: begin
                done   = 1'b1;
                w_next = DIV_IDLE;
            end
            default: w_next = DIV_IDLE;
        endcase
    end

    // State register, operand capture and iteration datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= DIV_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                DIV_IDLE: begin
                    if (start && !annul) begin
                        r_shift   <= {33'd0, abs32(op_a, signed_div)};
                        r_divisor <= abs32(op_b, signed_div);
                        r_neg_q   <= signed_div & (op_a[REG_W-1] ^ op_b[REG_W-1]);
                        r_neg_r   <= signed_div & op_a[REG_W-1];
                        r_cnt     <= '0;
                    end
                end
                DIV_CALC: begin
                    if (!annul) begin
                        r_shift <= w_step;
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                DIV_ZERO: begin
                    r_shift <= '0;
                    r_neg_q <= 1'b0;
                    r_neg_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Quotient negated on differing signs; remainder follows the dividend sign
    assign quotient  = r_neg_q ? (~r_shift[31:0] + 32'd1)  : r_shift[31:0];
    assign remainder = r_neg_r ? (~r_shift[63:32] + 32'd1) : r_shift[63:32];

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage
//  Description : Execute stage: logic/shift/arith/move, single-cycle
//                multiply, iterative divide with pipeline stall request.
//  Revision    : 1.0  initial release
// ============================================================================
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ALUOP_W-1:0]    aluop_i,
    input  logic [ALUTYPE_W-1:0]  aluoptype_i,
    input  logic [REG_W-1:0]      reg1_data_i,
    input  logic [REG_W-1:0]      reg2_data_i,
    input  logic                  wreg_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic [REG_W-1:0]      hi_i,
    input  logic [REG_W-1:0]      lo_i,
    input  logic                  flush_i,
    output logic                  wreg_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic [REG_W-1:0]      wdata_o,
    output logic                  whilo_o,
    output logic [REG_W-1:0]      hi_o,
    output logic [REG_W-1:0]      lo_o,
    output logic                  stallreq_o
);

    logic             w_is_mult;
    logic             w_is_div;
    logic             w_is_mt;
    logic             w_sub;
    logic [REG_W-1:0] w_sum;
    logic [REG_W-1:0] w_result;
    logic [63:0]      w_mul_a;
    logic [63:0]      w_mul_b;
    logic [63:0]      w_prod;
    logic             w_div_busy;
    logic             w_div_done;
    logic [REG_W-1:0] w_quot;
    logic [REG_W-1:0] w_rem;

    assign w_is_mult = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MULTU_OP);
    assign w_is_div  = (aluop_i == EXE_DIV_OP)  || (aluop_i == EXE_DIVU_OP);
    assign w_is_mt   = (aluop_i == EXE_MTHI_OP) || (aluop_i == EXE_MTLO_OP);
    assign w_sub     = (aluop_i == EXE_SUB_OP)  || (aluop_i == EXE_SUBU_OP);
    assign w_sum     = reg1_data_i + (w_sub ? (~reg2_data_i + 32'd1) : reg2_data_i);

    // Sign-extending to 64 bits makes the low 64 product bits right for MULT as well as MULTU
    assign w_mul_a = {{32{reg1_data_i[31] & (aluop_i == EXE_MULT_OP)}}, reg1_data_i};
    assign w_mul_b = {{32{reg2_data_i[31] & (aluop_i == EXE_MULT_OP)}}, reg2_data_i};
    assign w_prod  = w_mul_a * w_mul_b;

    ex_stage_div_unit #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_unit (
        .clk        (clk),
        .rst        (rst),
        .start      (w_is_div),
        .signed_div (aluop_i == EXE_DIV_OP),
        .annul      (flush_i),
        .op_a       (reg1_data_i),
        .op_b       (reg2_data_i),
        .busy       (w_div_busy),
        .done       (w_div_done),
        .quotient   (w_quot),
        .remainder  (w_rem)
    );

    // GPR write data selected by result class
    always_comb begin
        w_result = '0;
        case (aluoptype_i)
            EXE_RES_LOGIC: begin
                case (aluop_i)
                    EXE_AND_OP: w_result = reg1_data_i & reg2_data_i;
                    EXE_OR_OP:  w_result = reg1_data_i | reg2_data_i;
                    EXE_XOR_OP: w_result = reg1_data_i ^ reg2_data_i;
                    EXE_NOR_OP: w_result = ~(reg1_data_i | reg2_data_i);
                    default:    w_result = '0;
                endcase
            end
            EXE_RES_SHIFT: begin
                case (aluop_i)
                    EXE_SLL_OP: w_result = reg1_data_i << reg2_data_i[4:0];
                    EXE_SRL_OP: w_result = reg1_data_i >> reg2_data_i[4:0];
                    EXE_SRA_OP: w_result = $signed(reg1_data_i) >>> reg2_data_i[4:0];
                    default:    w_result = '0;
                endcase
            end
            EXE_RES_ARITH: begin
                case (aluop_i)
                    EXE_ADD_OP, EXE_ADDU_OP,
                    EXE_SUB_OP, EXE_SUBU_OP: w_result = w_sum;
                    EXE_SLT_OP:  w_result = ($signed(reg1_data_i) < $signed(reg2_data_i)) ? 32'd1 : 32'd0;
                    EXE_SLTU_OP: w_result = (reg1_data_i < reg2_data_i) ? 32'd1 : 32'd0;
                    default:     w_result = '0;
                endcase
            end
            EXE_RES_MOVE: begin
                case (aluop_i)
                    EXE_MFHI_OP: w_result = hi_i;
                    EXE_MFLO_OP: w_result = lo_i;
                    default:     w_result = '0;
                endcase
            end
            default: w_result = '0;
        endcase
    end

    // Writeback bundle and stall request; reset and flush silence everything
    always_comb begin
        wreg_o     = 1'b0;
        rd_addr_o  = '0;
        wdata_o    = '0;
        whilo_o    = 1'b0;
        hi_o       = '0;
        lo_o       = '0;
        stallreq_o = 1'b0;
        if (!rst && !flush_i) begin
            wdata_o    = w_result;
            stallreq_o = w_div_busy;
            if (!(w_is_mult || w_is_div || w_is_mt)) begin
                wreg_o    = wreg_i;
                rd_addr_o = rd_addr_i;
            end
            if (w_is_mult) begin
                whilo_o = 1'b1;
                hi_o    = w_prod[63:32];
                lo_o    = w_prod[31:0];
            end else if (w_is_div && w_div_done) begin
                whilo_o = 1'b1;
                hi_o    = w_rem;
                lo_o    = w_quot;
            end else if (aluop_i == EXE_MTHI_OP) begin
                whilo_o = 1'b1;
                hi_o    = reg1_data_i;
                lo_o    = lo_i;
            end else if (aluop_i == EXE_MTLO_OP) begin
                whilo_o = 1'b1;
                hi_o    = hi_i;
                lo_o    = reg1_data_i;
            end
        end
    end

endmodule
`default_nettype wire
